riscv_str_ops_issue: RTL and testbench

Issue and buffer stage directly upstream of the riscv_str_ops datapath. It accepts string-op requests from the EX stage over a valid/ready handshake and queues them in a small FIFO. Each request is issued to the datapath for exactly one cycle, and the datapath result is captured into a registered output with valid/ready toward writeback. The stage also annotates each result with NUL-terminator information taken from the source operand.

---
 rtl/riscv_str_ops_issue_if.sv | 35 +++
 rtl/riscv_str_ops_issue.sv | 117 +++++++++++
 tb/tb_riscv_str_ops_issue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_str_ops_issue_if.sv
// Bundles the three buses around the string-op issue stage:
// the EX request channel, the datapath issue port, and the writeback result channel.
interface riscv_str_ops_issue_if #(
    parameter int OP_WIDTH = 3
);
    logic                flush_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [OP_WIDTH-1:0] in_operator_i;
    logic [31:0]         in_operand_i;
    logic                str_enable_o;
    logic [OP_WIDTH-1:0] str_operator_o;
    logic [31:0]         str_operand_o;
    logic [31:0]         str_result_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         out_data_o;
    logic                out_nul_o;
    logic [2:0]          out_len_o;
    logic                busy_o;

    // Issue stage side
    modport slave (
        input  flush_i, in_valid_i, in_operator_i, in_operand_i, str_result_i, out_ready_i,
        output in_ready_o, str_enable_o, str_operator_o, str_operand_o,
               out_valid_o, out_data_o, out_nul_o, out_len_o, busy_o
    );

    // EX / datapath / writeback side
    modport master (
        output flush_i, in_valid_i, in_operator_i, in_operand_i, str_result_i, out_ready_i,
        input  in_ready_o, str_enable_o, str_operator_o, str_operand_o,
               out_valid_o, out_data_o, out_nul_o, out_len_o, busy_o
    );
endinterface

// File: rtl/riscv_str_ops_issue.sv
// String-op issue stage: small FIFO of requests, one-cycle issue to the
// combinational datapath, registered result with NUL-terminator annotation.
module riscv_str_ops_issue #(
    parameter int DEPTH    = 2,
    parameter int OP_WIDTH = 3   // string-op operator field width
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_str_ops_issue_if.slave  bus
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [OP_WIDTH-1:0] op_mem_q  [DEPTH];
    logic [31:0]         opd_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_nul_q, out_nul_d;
    logic [2:0]    out_len_q, out_len_d;

    logic          full, empty, push, issue;
    logic [OP_WIDTH-1:0] head_op;
    logic [31:0]   head_opd;
    logic [2:0]    head_len;

    // Ready comes from the registered count only, so a pop never re-opens a full FIFO early.
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign push  = bus.in_valid_i && !full;
    assign issue = !empty && (!out_valid_q || bus.out_ready_i) && !bus.flush_i;

    assign head_op  = empty ? '0 : op_mem_q[rd_ptr_q];
    assign head_opd = empty ? '0 : opd_mem_q[rd_ptr_q];

    assign bus.in_ready_o     = !full;
    assign bus.str_enable_o   = issue;
    assign bus.str_operator_o = head_op;
    assign bus.str_operand_o  = head_opd;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_data_o     = out_data_q;
    assign bus.out_nul_o      = out_nul_q;
    assign bus.out_len_o      = out_len_q;
    assign bus.busy_o         = !empty || out_valid_q;

    // First zero byte of the head operand, scanning from byte 0 upward; 4 means none.
    always_comb begin
        head_len = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (head_opd[8*i +: 8] == 8'h00) head_len = 3'(i);
        end
    end

    // Next-state: flush wins over push/issue; otherwise push, issue/pop and drain.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_nul_d   = out_nul_q;
        out_len_d   = out_len_q;
        if (bus.flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (issue) begin
                rd_ptr_d    = rd_ptr_q + PW'(1);
                out_valid_d = 1'b1;
                out_data_d  = bus.str_result_i;
                out_nul_d   = (head_len != 3'd4);
                out_len_d   = head_len;
            end else if (bus.out_ready_i) begin
                out_valid_d = 1'b0;
            end
            case ({push, issue})
                2'b10:   cnt_d = cnt_q + (PW+1)'(1);
                2'b01:   cnt_d = cnt_q - (PW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_nul_q   <= 1'b0;
            out_len_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_nul_q   <= out_nul_d;
            out_len_q   <= out_len_d;
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !bus.flush_i) begin
            op_mem_q[wr_ptr_q]  <= bus.in_operator_i;
            opd_mem_q[wr_ptr_q] <= bus.in_operand_i;
        end
    end
endmodule

// File: tb/tb_riscv_str_ops_issue.sv
// Directed bench for riscv_str_ops_issue with a toy combinational datapath.
module tb_riscv_str_ops_issue;
    localparam int OPW = 3;
    localparam logic [OPW-1:0] OP_UPPER = 3'd1;
    localparam logic [OPW-1:0] OP_XOR   = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    riscv_str_ops_issue_if #(.OP_WIDTH(OPW)) bus ();

    riscv_str_ops_issue #(.DEPTH(2), .OP_WIDTH(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Toy datapath: UPPER clears bit 5 of each byte, anything else flips the upper half.
    always_comb begin
        if (bus.str_operator_o == OP_UPPER) bus.str_result_i = bus.str_operand_o & 32'hDFDF_DFDF;
        else                                bus.str_result_i = bus.str_operand_o ^ 32'hFFFF_0000;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs settle 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OPW-1:0] op, input logic [31:0] opd);
        bus.in_valid_i    = v;
        bus.in_operator_i = op;
        bus.in_operand_i  = opd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Fill to full with out_ready low: X1 in output reg, X2/X3 queued.
    task automatic fill_stalled(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.out_ready_i = 1'b0;
        drive(1'b1, OP_XOR, a); cyc();
        drive(1'b1, OP_XOR, b); cyc();
        drive(1'b1, OP_XOR, c); cyc();
        drive(1'b0, OP_XOR, 32'h0);
    endtask

    logic [31:0] exp_q [8];

    initial begin
        bus.flush_i       = 1'b0;
        bus.in_valid_i    = 1'b0;
        bus.in_operator_i = '0;
        bus.in_operand_i  = '0;
        bus.out_ready_i   = 1'b1;
        do_reset();

        // Reset state
        chk("rst_in_ready",  32'(bus.in_ready_o),   32'd1);
        chk("rst_str_en",    32'(bus.str_enable_o), 32'd0);
        chk("rst_busy",      32'(bus.busy_o),       32'd0);
        chk("rst_out_valid", 32'(bus.out_valid_o),  32'd0);
        chk("rst_out_data",  bus.out_data_o,        32'd0);
        chk("rst_nul_len",   {28'd0, bus.out_nul_o, bus.out_len_o}, 32'd0);
        chk("rst_str_opd",   bus.str_operand_o,     32'd0);

        // 1: single UPPER op, latency and busy
        drive(1'b1, OP_UPPER, 32'h6463_6261);
        chk("t1_no_bypass", 32'(bus.str_enable_o), 32'd0);
        cyc();
        drive(1'b0, OP_UPPER, 32'h0);
        chk("t1_str_en",    32'(bus.str_enable_o),   32'd1);
        chk("t1_str_op",    32'(bus.str_operator_o), 32'(OP_UPPER));
        chk("t1_str_opd",   bus.str_operand_o,       32'h6463_6261);
        chk("t1_valid_lo",  32'(bus.out_valid_o),    32'd0);
        cyc();
        chk("t1_str_en_1x", 32'(bus.str_enable_o),   32'd0);
        chk("t1_valid",     32'(bus.out_valid_o),    32'd1);
        chk("t1_data",      bus.out_data_o,          32'h4443_4241);
        chk("t1_nul",       32'(bus.out_nul_o),      32'd0);
        chk("t1_len",       32'(bus.out_len_o),      32'd4);
        chk("t1_busy",      32'(bus.busy_o),         32'd1);
        cyc();
        chk("t1_valid_clr", 32'(bus.out_valid_o),    32'd0);
        chk("t1_busy_clr",  32'(bus.busy_o),         32'd0);

        // 2: NUL scan
        drive(1'b1, OP_UPPER, 32'h0000_6968); cyc();
        drive(1'b1, OP_UPPER, 32'h6162_6300); cyc();
        drive(1'b0, OP_UPPER, 32'h0);
        chk("t2a_data", bus.out_data_o,     32'h0000_4948);
        chk("t2a_nul",  32'(bus.out_nul_o), 32'd1);
        chk("t2a_len",  32'(bus.out_len_o), 32'd2);
        cyc();
        chk("t2b_data", bus.out_data_o,     32'h4142_4300);
        chk("t2b_nul",  32'(bus.out_nul_o), 32'd1);
        chk("t2b_len",  32'(bus.out_len_o), 32'd0);
        cyc();
        chk("t2_idle",  32'(bus.busy_o),    32'd0);

        // 3: back-pressure, full, no full-bypass, ordered drain with wrap
        fill_stalled(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        chk("t3_hold_data", bus.out_data_o,       32'hEEEE_1111);
        chk("t3_full",      32'(bus.in_ready_o),  32'd0);
        chk("t3_no_issue",  32'(bus.str_enable_o), 32'd0);
        chk("t3_head",      bus.str_operand_o,    32'h2222_2222);
        drive(1'b1, OP_XOR, 32'h4444_4444);
        cyc();
        drive(1'b0, OP_XOR, 32'h0);
        chk("t3_hold2",     bus.out_data_o,       32'hEEEE_1111);
        chk("t3_hold_len",  32'(bus.out_len_o),   32'd4);
        chk("t3_still_full", 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        #1;
        chk("t3_release_iss", 32'(bus.str_enable_o), 32'd1);
        chk("t3_pop_no_bypass", 32'(bus.in_ready_o), 32'd0);
        cyc();
        chk("t3_d2", bus.out_data_o, 32'hDDDD_2222);
        cyc();
        chk("t3_d3", bus.out_data_o, 32'hCCCC_3333);
        cyc();
        chk("t3_drained", 32'(bus.out_valid_o), 32'd0);
        chk("t3_no_extra", 32'(bus.busy_o),     32'd0);

        // 4: back-to-back, 1 result per cycle
        for (int k = 0; k < 8; k++) exp_q[k] = (32'h0000_0101 * (k + 1)) ^ 32'hFFFF_0000;
        for (int e = 1; e <= 9; e++) begin
            if (e <= 8) drive(1'b1, OP_XOR, 32'h0000_0101 * e);
            else        drive(1'b0, OP_XOR, 32'h0);
            cyc();
            if (e == 1) begin
                chk("t4_first_lat", 32'(bus.out_valid_o), 32'd0);
            end else begin
                chk($sformatf("t4_v%0d", e - 2), 32'(bus.out_valid_o), 32'd1);
                chk($sformatf("t4_d%0d", e - 2), bus.out_data_o, exp_q[e-2]);
            end
        end
        drive(1'b0, OP_XOR, 32'h0);
        chk("t4_len", 32'(bus.out_len_o), 32'd2);
        cyc();
        chk("t4_end", 32'(bus.out_valid_o), 32'd0);

        // 5: flush with full FIFO, pending result and a push attempt
        fill_stalled(32'h1212_1212, 32'h3434_3434, 32'h5656_5656);
        bus.flush_i = 1'b1;
        drive(1'b1, OP_XOR, 32'h7878_7878);
        chk("t5_flush_gates", 32'(bus.str_enable_o), 32'd0);
        cyc();
        bus.flush_i = 1'b0;
        drive(1'b0, OP_XOR, 32'h0);
        chk("t5_valid", 32'(bus.out_valid_o),  32'd0);
        chk("t5_en",    32'(bus.str_enable_o), 32'd0);
        chk("t5_busy",  32'(bus.busy_o),       32'd0);
        chk("t5_ready", 32'(bus.in_ready_o),   32'd1);
        // flush with an accepted push into an empty FIFO: entry discarded
        bus.flush_i = 1'b1;
        drive(1'b1, OP_XOR, 32'h9999_9999);
        chk("t5b_ready", 32'(bus.in_ready_o), 32'd1);
        cyc();
        bus.flush_i = 1'b0;
        drive(1'b0, OP_XOR, 32'h0);
        chk("t5b_busy", 32'(bus.busy_o), 32'd0);
        chk("t5b_head", bus.str_operand_o, 32'd0);

        // 6: reset while full with pending result
        fill_stalled(32'h1200_3456, 32'h0000_0001, 32'h0000_0002);
        chk("t6_pre_len", 32'(bus.out_len_o), 32'd2);
        chk("t6_pre_nul", 32'(bus.out_nul_o), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.out_valid_o),  32'd0);
        chk("t6_data",  bus.out_data_o,        32'd0);
        chk("t6_nullen", {28'd0, bus.out_nul_o, bus.out_len_o}, 32'd0);
        chk("t6_ready", 32'(bus.in_ready_o),   32'd1);
        chk("t6_busy",  32'(bus.busy_o),       32'd0);
        chk("t6_en",    32'(bus.str_enable_o), 32'd0);
        cyc();
        chk("t6_quiet", 32'(bus.out_valid_o),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
